// File: rtl/ser_tx_pkg.sv
// Shared types and sizing helpers for the ser_tx parallel-to-serial transmitter.
// The counter width must cover the full 0..WIDTH range.
package ser_tx_pkg;

    localparam int SER_TX_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ser_tx_shreg.sv
// Load/shift register that holds the bits not yet sent; ser_o is the next bit to present.
// Bit 0 or bit WIDTH-1 goes out directly on load, so only WIDTH-1 bits are stored here.
module ser_tx_shreg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             ser_o
);

    logic [WIDTH-2:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = LSB_FIRST ? din_i[WIDTH-1:1] : din_i[WIDTH-2:0];
        end else if (shift_i) begin
            sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign ser_o = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-2];

endmodule

// File: rtl/ser_tx.sv
// Serial transmitter: accepts a word on valid/ready, shifts it out one bit per clk_en tick.
// Optional even-parity bit after the data when SER_TX_PARITY_EN is defined.
module ser_tx
    import ser_tx_pkg::*;
#(
    parameter int WIDTH     = SER_TX_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdata,
    output logic             frame,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sdata_q, sdata_d;
    logic          frame_q, frame_d;
    logic          done_q, done_d;
    logic          sh_load;
    logic          sh_shift;
    logic          sh_next;
`ifdef SER_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    ser_tx_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .din_i   (din),
        .ser_o   (sh_next)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sdata_d  = sdata_q;
        frame_d  = frame_q;
        done_d   = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
`ifdef SER_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        sh_load = 1'b1;
                        sdata_d = LSB_FIRST ? din[0] : din[WIDTH-1];
                        frame_d = 1'b1;
                        cnt_d   = '0;
                        state_d = SHIFT;
`ifdef SER_TX_PARITY_EN
                        par_d   = ^din;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt_q == LAST_BIT) begin
`ifdef SER_TX_PARITY_EN
                        sdata_d = par_q;
                        state_d = PARITY;
`else
                        sdata_d = 1'b1;
                        frame_d = 1'b0;
                        state_d = GAP;
`endif
                    end else begin
                        sh_shift = 1'b1;
                        sdata_d  = sh_next;
                        cnt_d    = cnt_q + CW'(1);
                    end
                end
                PARITY: begin
                    sdata_d = 1'b1;
                    frame_d = 1'b0;
                    state_d = GAP;
                end
                GAP: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    sdata_d = 1'b1;
                    frame_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // done_q is loaded every clk edge so the pulse clears even while clk_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sdata_q <= 1'b1;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SER_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sdata_q <= sdata_d;
            frame_q <= frame_d;
            done_q  <= done_d;
`ifdef SER_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign load_ready = (state_q == IDLE);
    assign sdata      = sdata_q;
    assign frame      = frame_q;
    assign done       = done_q;

endmodule
